csa_pipe: RTL and testbench



---
 rtl/csa_pkg.sv | 25 ++
 rtl/csa_merge_level.sv | 67 ++++++
 rtl/csa_pipe.sv | 125 ++++++++++++
 tb/tb_csa_pipe.sv | 386 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csa_pkg.sv
// Shared definitions for the pipelined conditional-sum adder/subtractor.
package csa_pkg;

    // Ceiling log2 for elaboration-time sizing (number of merge levels).
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // Per-beat sideband that travels with the data through every stage.
    // cin drives the final carry-in select; a_msb/be_msb feed the overflow flag.
    typedef struct packed {
        logic valid;
        logic cin;
        logic a_msb;
        logic be_msb;
    } side_t;

endpackage

// File: rtl/csa_merge_level.sv
// One conditional-sum merge level: pairs of 2^(LEVEL-1)-bit blocks are fused
// into 2^LEVEL-bit blocks, each still holding both carry-in hypotheses, then
// registered behind the pipeline-wide enable.
module csa_merge_level
    import csa_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int LEVEL = 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              en,
    input  logic [WIDTH-1:0]                  sum0,
    input  logic [WIDTH-1:0]                  sum1,
    input  logic [(WIDTH >> (LEVEL - 1))-1:0] carry0,
    input  logic [(WIDTH >> (LEVEL - 1))-1:0] carry1,
    input  side_t                             side,
    output logic [WIDTH-1:0]                  sum0_q,
    output logic [WIDTH-1:0]                  sum1_q,
    output logic [(WIDTH >> LEVEL)-1:0]       carry0_q,
    output logic [(WIDTH >> LEVEL)-1:0]       carry1_q,
    output side_t                             side_q
);

    localparam int HALF = 1 << (LEVEL - 1);
    localparam int NB   = WIDTH >> LEVEL;

    logic [WIDTH-1:0] sum0_m;
    logic [WIDTH-1:0] sum1_m;
    logic [NB-1:0]    carry0_m;
    logic [NB-1:0]    carry1_m;

    // Lower half passes through; the upper half's hypothesis is chosen by the
    // lower half's carry-out under the same block carry-in assumption.
    always_comb begin
        sum0_m   = sum0;
        sum1_m   = sum1;
        carry0_m = '0;
        carry1_m = '0;
        for (int j = 0; j < NB; j++) begin
            sum0_m[(2*j+1)*HALF +: HALF] = carry0[2*j] ? sum1[(2*j+1)*HALF +: HALF]
                                                       : sum0[(2*j+1)*HALF +: HALF];
            sum1_m[(2*j+1)*HALF +: HALF] = carry1[2*j] ? sum1[(2*j+1)*HALF +: HALF]
                                                       : sum0[(2*j+1)*HALF +: HALF];
            carry0_m[j] = carry0[2*j] ? carry1[2*j+1] : carry0[2*j+1];
            carry1_m[j] = carry1[2*j] ? carry1[2*j+1] : carry0[2*j+1];
        end
    end

    // Stage register: cleared by reset, frozen whenever the pipeline stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum0_q   <= '0;
            sum1_q   <= '0;
            carry0_q <= '0;
            carry1_q <= '0;
            side_q   <= '0;
        end else if (en) begin
            sum0_q   <= sum0_m;
            sum1_q   <= sum1_m;
            carry0_q <= carry0_m;
            carry1_q <= carry1_m;
            side_q   <= side;
        end
    end

endmodule

// File: rtl/csa_pipe.sv
// Pipelined conditional-sum adder/subtractor with a valid/ready stream.
// Handshake: a beat moves when valid && ready on a rising edge; the producer
// keeps valid and data stable until it moves. in_ready = !out_valid ||
// out_ready, and that single signal enables every stage, so bubbles are not
// squeezed out. Latency is LEVELS+1 cycles (cell stage plus LEVELS merges).
module csa_pipe
    import csa_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int LEVELS = clog2(WIDTH);
    // Carries of all levels are packed back to back: level g holds WIDTH>>g
    // bits starting at 2*WIDTH - 2*(WIDTH>>g); 2*WIDTH-1 bits in total.
    localparam int CW = 2 * WIDTH - 1;

    logic                         en;
    logic [WIDTH-1:0]             be;
    logic [WIDTH-1:0]             prop;
    logic [WIDTH-1:0]             c_s0;
    logic [WIDTH-1:0]             c_s1;
    logic [WIDTH-1:0]             c_c0;
    logic [WIDTH-1:0]             c_c1;
    logic [WIDTH-1:0]             cell_s0;
    logic [WIDTH-1:0]             cell_s1;
    logic [WIDTH-1:0]             cell_c0;
    logic [WIDTH-1:0]             cell_c1;
    side_t                        cell_side;
    logic [LEVELS:0][WIDTH-1:0]   sum0_st;
    logic [LEVELS:0][WIDTH-1:0]   sum1_st;
    logic [CW-1:0]                carry0_st;
    logic [CW-1:0]                carry1_st;
    side_t [LEVELS:0]             side_st;
    side_t                        last;

    assign in_ready = !out_valid || out_ready;
    assign en       = in_ready;

    // Cell stage: per-bit sum/carry for both carry-in hypotheses; bit 0 is
    // resolved against cin right away so block 0 never needs a late select.
    always_comb begin
        be      = sub ? ~b : b;
        prop    = a ^ be;
        c_s0    = prop;
        c_s1    = ~prop;
        c_c0    = a & be;
        c_c1    = a | be;
        c_s0[0] = prop[0] ^ cin;
        c_s1[0] = prop[0] ^ cin;
        c_c0[0] = (a[0] & be[0]) | (prop[0] & cin);
        c_c1[0] = (a[0] & be[0]) | (prop[0] & cin);
    end

    // Cell stage register, captures a beat (or a bubble) whenever enabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            cell_s0   <= '0;
            cell_s1   <= '0;
            cell_c0   <= '0;
            cell_c1   <= '0;
            cell_side <= '0;
        end else if (en) begin
            cell_s0   <= c_s0;
            cell_s1   <= c_s1;
            cell_c0   <= c_c0;
            cell_c1   <= c_c1;
            cell_side <= '{valid: in_valid, cin: cin, a_msb: a[WIDTH-1], be_msb: be[WIDTH-1]};
        end
    end

    assign sum0_st[0]            = cell_s0;
    assign sum1_st[0]            = cell_s1;
    assign carry0_st[WIDTH-1:0]  = cell_c0;
    assign carry1_st[WIDTH-1:0]  = cell_c1;
    assign side_st[0]            = cell_side;

    for (genvar g = 1; g <= LEVELS; g++) begin : g_level
        localparam int NB_IN   = WIDTH >> (g - 1);
        localparam int NB_OUT  = WIDTH >> g;
        localparam int OFF_IN  = 2 * WIDTH - 2 * NB_IN;
        localparam int OFF_OUT = 2 * WIDTH - 2 * NB_OUT;

        csa_merge_level #(
            .WIDTH (WIDTH),
            .LEVEL (g)
        ) u_merge (
            .clk      (clk),
            .rst      (rst),
            .en       (en),
            .sum0     (sum0_st[g-1]),
            .sum1     (sum1_st[g-1]),
            .carry0   (carry0_st[OFF_IN +: NB_IN]),
            .carry1   (carry1_st[OFF_IN +: NB_IN]),
            .side     (side_st[g-1]),
            .sum0_q   (sum0_st[g]),
            .sum1_q   (sum1_st[g]),
            .carry0_q (carry0_st[OFF_OUT +: NB_OUT]),
            .carry1_q (carry1_st[OFF_OUT +: NB_OUT]),
            .side_q   (side_st[g])
        );
    end

    assign last      = side_st[LEVELS];
    assign out_valid = last.valid;
    // Final carry-in select; both hypotheses agree because bit 0 was resolved
    // in the cell, but the select keeps the classic structure intact.
    assign s         = last.cin ? sum1_st[LEVELS] : sum0_st[LEVELS];
    assign cout      = last.cin ? carry1_st[CW-1] : carry0_st[CW-1];
    assign ovf       = (last.a_msb == last.be_msb) && (s[WIDTH-1] != last.a_msb);

endmodule

// File: tb/tb_csa_pipe.sv
// Bench for csa_pipe: directed cases and back-pressure/reset scenarios at
// WIDTH=16, plus randomized streams at WIDTH=4, 16 and 64 against an
// arithmetic reference model.
module tb_csa_pipe;

    localparam int NBEATS = 10000;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] s;
    logic        cout;
    logic        ovf;

    int          n_checks = 0;
    int          n_err    = 0;
    int          n_pop    = 0;
    logic        x_go     = 1'b0;
    logic [65:0] exp_q[$];

    csa_pipe #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .cout      (cout),
        .ovf       (ovf)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {ovf, cout, s} from plain arithmetic on w-bit operands.
    function automatic logic [65:0] model(input int w, input logic [63:0] ma, input logic [63:0] mb,
                                          input logic mcin, input logic msub);
        logic [63:0] mask;
        logic [63:0] mbe;
        logic [63:0] ms;
        logic [64:0] full;
        logic        mc;
        logic        mo;
        mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        mbe  = (msub ? ~mb : mb) & mask;
        full = {1'b0, ma & mask} + {1'b0, mbe} + {64'd0, mcin};
        ms   = full[63:0] & mask;
        mc   = full[w];
        mo   = (ma[w-1] == mbe[w-1]) && (ms[w-1] != ma[w-1]);
        return {mo, mc, ms};
    endfunction

    // Random operand with a bias toward carry/overflow corner values.
    function automatic logic [63:0] pick(input int w);
        logic [63:0] mask;
        logic [63:0] r;
        mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        r    = {$urandom, $urandom};
        case ($urandom_range(0, 7))
            0: r = '0;
            1: r = '1;
            2: r = mask >> 1;
            3: r = ~(mask >> 1);
            default: ;
        endcase
        return r & mask;
    endfunction

    task automatic chk(input string nm, input logic [65:0] act, input logic [65:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // scoreboard for the WIDTH=16 instance
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            chk("in_ready_rule", in_ready, !out_valid || out_ready);
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("w16_spurious_out", 1, 0);
                end else begin
                    chk("w16_result", {ovf, cout, 64'(s)}, exp_q[0]);
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        n_pop++;
                    end
                end
            end
            if (in_valid && in_ready) exp_q.push_back(model(16, 64'(a), 64'(b), cin, sub));
        end
    end

    // driver: present one beat and hold it until accepted (bounded)
    task automatic send(input logic [15:0] ta, input logic [15:0] tb2, input logic tcin, input logic tsub);
        int   w;
        logic took;
        in_valid = 1'b1;
        a = ta;
        b = tb2;
        cin = tcin;
        sub = tsub;
        took = 1'b0;
        w = 0;
        while (!took && w < 200) begin
            @(negedge clk);
            took = in_ready;
            @(posedge clk);
            #1;
            w++;
        end
        in_valid = 1'b0;
        if (!took) chk("send_timeout", took, 1);
    endtask

    task automatic directed(input string nm, input logic [15:0] ta, input logic [15:0] tb2,
                            input logic tcin, input logic tsub,
                            input logic [15:0] es, input logic ec, input logic eo);
        int lat;
        send(ta, tb2, tcin, tsub);
        lat = 1;
        while (lat < 20) begin
            @(negedge clk);
            if (out_valid) break;
            lat++;
            @(posedge clk);
        end
        chk({nm, "_latency"}, lat, 5);
        chk({nm, "_s"}, s, es);
        chk({nm, "_cout"}, cout, ec);
        chk({nm, "_ovf"}, ovf, eo);
        @(posedge clk);
        #1;
    endtask

    // extra widths: randomized streams with their own scoreboards
    for (genvar gi = 0; gi < 2; gi++) begin : g_x
        localparam int XW = (gi == 0) ? 4 : 64;
        logic          xv;
        logic          xrdy;
        logic          xov;
        logic          xordy;
        logic          xcin;
        logic          xsub;
        logic          xcout;
        logic          xovf;
        logic [XW-1:0] xa;
        logic [XW-1:0] xb;
        logic [XW-1:0] xs;
        logic          x_done;
        logic          x_stop;
        logic [65:0]   xq[$];

        csa_pipe #(.WIDTH(XW)) u_x (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (xv),
            .in_ready  (xrdy),
            .a         (xa),
            .b         (xb),
            .cin       (xcin),
            .sub       (xsub),
            .out_valid (xov),
            .out_ready (xordy),
            .s         (xs),
            .cout      (xcout),
            .ovf       (xovf)
        );

        always @(negedge clk) begin
            if (rst) begin
                xq.delete();
            end else begin
                if (xov) begin
                    if (xq.size() == 0) begin
                        chk($sformatf("w%0d_spurious_out", XW), 1, 0);
                    end else begin
                        chk($sformatf("w%0d_result", XW), {xovf, xcout, 64'(xs)}, xq[0]);
                        if (xordy) void'(xq.pop_front());
                    end
                end
                if (xv && xrdy) xq.push_back(model(XW, 64'(xa), 64'(xb), xcin, xsub));
            end
        end

        initial begin
            logic [63:0] ta;
            logic [63:0] tb2;
            int          w;
            logic        took;
            xv = 1'b0; xa = '0; xb = '0; xcin = 1'b0; xsub = 1'b0; xordy = 1'b1;
            x_done = 1'b0; x_stop = 1'b0;
            wait (x_go);
            @(posedge clk);
            #1;
            fork
                begin
                    for (int i = 0; i < NBEATS; i++) begin
                        if ($urandom_range(0, 3) == 0) begin
                            @(posedge clk);
                            #1;
                        end
                        ta = pick(XW);
                        tb2 = pick(XW);
                        xa = ta[XW-1:0];
                        xb = tb2[XW-1:0];
                        xcin = 1'($urandom_range(0, 1));
                        xsub = 1'($urandom_range(0, 1));
                        xv = 1'b1;
                        took = 1'b0;
                        w = 0;
                        while (!took && w < 200) begin
                            @(negedge clk);
                            took = xrdy;
                            @(posedge clk);
                            #1;
                            w++;
                        end
                        xv = 1'b0;
                        if (!took) begin
                            chk($sformatf("w%0d_send_timeout", XW), took, 1);
                            break;
                        end
                    end
                    x_stop = 1'b1;
                end
                begin
                    while (!x_stop) begin
                        xordy = ($urandom_range(0, 2) != 0);
                        @(posedge clk);
                        #1;
                    end
                    xordy = 1'b1;
                end
            join
            for (int c = 0; c < 100 && xq.size() != 0; c++) begin
                @(posedge clk);
                #1;
            end
            chk($sformatf("w%0d_drain", XW), xq.size(), 0);
            x_done = 1'b1;
        end
    end

    // main sequence
    initial begin
        int   p0;
        logic stop;
        logic [63:0] t1;
        logic [63:0] t2;
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
        stop = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_in_ready", in_ready, 1);
        chk("reset_s", s, 0);
        chk("reset_cout", cout, 0);
        chk("reset_ovf", ovf, 0);
        @(posedge clk);
        #1;

        // pin the reference model with hand-computed values
        chk("model_add", model(16, 64'h1234, 64'h4321, 1'b0, 1'b0), {2'b00, 64'h5555});
        chk("model_sub", model(16, 64'h0005, 64'h0007, 1'b1, 1'b1), {2'b00, 64'hFFFE});
        chk("model_w4", model(4, 64'hF, 64'h1, 1'b0, 1'b0), {2'b01, 64'h0});
        chk("model_w64", model(64, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0),
            {2'b10, 64'h8000_0000_0000_0000});

        directed("add_basic",  16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
        directed("carry_full", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
        directed("add_ovf",    16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        directed("sub_borrow", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        directed("sub_ovf",    16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        directed("sub_cin0",   16'h0005, 16'h0003, 1'b0, 1'b1, 16'h0001, 1'b1, 1'b0);

        // back-pressure: 8 beats back to back, out_ready low in cycles 6..9
        p0 = n_pop;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    t1 = pick(16);
                    t2 = pick(16);
                    send(t1[15:0], t2[15:0], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                end
            end
            begin
                for (int c = 0; c < 12; c++) begin
                    out_ready = !(c >= 6 && c <= 9);
                    @(negedge clk);
                    if (c >= 6 && c <= 9) begin
                        chk("bp_in_ready", in_ready, 0);
                        chk("bp_out_valid", out_valid, 1);
                    end
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        for (int c = 0; c < 40 && exp_q.size() != 0; c++) begin
            @(posedge clk);
            #1;
        end
        chk("bp_count", n_pop - p0, 8);

        // reset mid-stream: three beats in flight are discarded
        p0 = n_pop;
        for (int i = 0; i < 3; i++) begin
            t1 = pick(16);
            t2 = pick(16);
            send(t1[15:0], t2[15:0], 1'b0, 1'b0);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_s", s, 0);
        @(posedge clk);
        #1;
        repeat (8) @(posedge clk);
        #1;
        chk("midrst_no_emit", n_pop - p0, 0);
        directed("after_rst", 16'hA5A5, 16'h5A5A, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);

        // randomized sweep at all three widths
        x_go = 1'b1;
        fork
            begin
                for (int i = 0; i < NBEATS; i++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                    t1 = pick(16);
                    t2 = pick(16);
                    send(t1[15:0], t2[15:0], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                end
                stop = 1'b1;
            end
            begin
                while (!stop) begin
                    out_ready = ($urandom_range(0, 2) != 0);
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        for (int c = 0; c < 100 && exp_q.size() != 0; c++) begin
            @(posedge clk);
            #1;
        end
        chk("w16_drain", exp_q.size(), 0);
        for (int c = 0; c < 60000 && !(g_x[0].x_done && g_x[1].x_done); c++) begin
            @(posedge clk);
            #1;
        end
        chk("extra_widths_done", {g_x[1].x_done, g_x[0].x_done}, 2'b11);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
